// File: rtl/alarm_tone_gen.sv
// alarm_tone_gen -- programmable square-wave tone generator for the panel buzzer.
//
// Plays tone A continuously, as a beep cadence (tone slot / silent slot), or as a
// two-tone A/B warble, for a finite number of beeps/pairs or indefinitely.
// Playback begins on a start pulse; busy is high while playing; done pulses for
// one cycle on natural completion, while stop aborts without a done pulse.
//
// Optional feature macro: ALARM_TONE_GEN_VOLUME_EN
//   defined   : a free-running 3-bit PWM counter gates the square wave by volume
//   undefined : volume is ignored, speaker is the raw square wave
//
// Ports
//   clk      in   system clock, rising edge
//   rst_n    in   asynchronous active-low reset
//   mode     in   [1:0] 0=OFF 1=CONT 2=BEEP 3=WARBLE, sampled on accepted start
//   count    in   [3:0] beeps / A-B pairs, 0 = indefinite, sampled on accepted start
//   start    in   single-cycle playback request
//   stop     in   abort playback
//   volume   in   [2:0] PWM level (volume build only)
//   speaker  out  square-wave drive
//   busy     out  high while playing
//   done     out  one-cycle pulse on natural completion
module alarm_tone_gen #(
    parameter int CLK_HZ    = 50_000_000,
    parameter int TONE_A_HZ = 440,
    parameter int TONE_B_HZ = 880,
    parameter int SLOT_MS   = 250
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] mode,
    input  logic [3:0] count,
    input  logic       start,
    input  logic       stop,
    input  logic [2:0] volume,
    output logic       speaker,
    output logic       busy,
    output logic       done
);

    localparam int HALF_A   = CLK_HZ / (2 * TONE_A_HZ);
    localparam int HALF_B   = CLK_HZ / (2 * TONE_B_HZ);
    localparam int SLOT     = (CLK_HZ / 1000) * SLOT_MS;
    localparam int HALF_MAX = (HALF_A > HALF_B) ? HALF_A : HALF_B;
    localparam int DIV_W    = (HALF_MAX > 1) ? $clog2(HALF_MAX) : 1;
    localparam int SLOT_W   = (SLOT > 1) ? $clog2(SLOT) : 1;

    localparam logic [DIV_W-1:0]  HALF_A_LAST = DIV_W'(HALF_A - 1);
    localparam logic [DIV_W-1:0]  HALF_B_LAST = DIV_W'(HALF_B - 1);
    localparam logic [DIV_W-1:0]  DIV_ONE     = DIV_W'(1);
    localparam logic [DIV_W-1:0]  DIV_ZERO    = DIV_W'(0);
    localparam logic [SLOT_W-1:0] SLOT_LAST   = SLOT_W'(SLOT - 1);
    localparam logic [SLOT_W-1:0] SLOT_ONE    = SLOT_W'(1);
    localparam logic [SLOT_W-1:0] SLOT_ZERO   = SLOT_W'(0);

    localparam logic [1:0] M_OFF  = 2'd0;
    localparam logic [1:0] M_CONT = 2'd1;
    localparam logic [1:0] M_BEEP = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_TONE = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    state_t            state_r;
    logic [1:0]        mode_r;
    logic [3:0]        remain_r;
    logic [SLOT_W-1:0] slot_r;
    logic [DIV_W-1:0]  div_r;
    logic              sq_r;
    logic              tone_b_r;   // warble: currently playing the B slot
    logic              busy_r;
    logic              done_r;

    // Playback FSM: slot/divider counters, square wave and handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= ST_IDLE;
            mode_r   <= 2'd0;
            remain_r <= 4'd0;
            slot_r   <= SLOT_ZERO;
            div_r    <= DIV_ZERO;
            sq_r     <= 1'b0;
            tone_b_r <= 1'b0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    // stop beats a simultaneous start; OFF requests are dropped
                    if (start && !stop && (mode != M_OFF)) begin
                        state_r  <= ST_TONE;
                        mode_r   <= mode;
                        remain_r <= count;
                        slot_r   <= SLOT_LAST;
                        div_r    <= HALF_A_LAST;
                        sq_r     <= 1'b0;
                        tone_b_r <= 1'b0;
                        busy_r   <= 1'b1;
                    end
                end
                ST_TONE: begin
                    if (stop) begin
                        state_r <= ST_IDLE;
                        sq_r    <= 1'b0;
                        busy_r  <= 1'b0;
                    end else if ((mode_r != M_CONT) && (slot_r == SLOT_ZERO)) begin
                        // slot boundary has priority over any divider toggle
                        slot_r <= SLOT_LAST;
                        if (mode_r == M_BEEP) begin
                            if (remain_r == 4'd1) begin
                                state_r <= ST_IDLE;
                                sq_r    <= 1'b0;
                                busy_r  <= 1'b0;
                                done_r  <= 1'b1;
                            end else begin
                                if (remain_r != 4'd0) begin
                                    remain_r <= remain_r - 4'd1;
                                end
                                state_r <= ST_GAP;
                                sq_r    <= 1'b0;
                            end
                        end else if (!tone_b_r) begin
                            // A -> B: speaker level is carried across the switch
                            tone_b_r <= 1'b1;
                            div_r    <= HALF_B_LAST;
                        end else if (remain_r == 4'd1) begin
                            state_r <= ST_IDLE;
                            sq_r    <= 1'b0;
                            busy_r  <= 1'b0;
                            done_r  <= 1'b1;
                        end else begin
                            if (remain_r != 4'd0) begin
                                remain_r <= remain_r - 4'd1;
                            end
                            tone_b_r <= 1'b0;
                            div_r    <= HALF_A_LAST;
                        end
                    end else begin
                        if (mode_r != M_CONT) begin
                            slot_r <= slot_r - SLOT_ONE;
                        end
                        if (div_r == DIV_ZERO) begin
                            sq_r  <= ~sq_r;
                            div_r <= tone_b_r ? HALF_B_LAST : HALF_A_LAST;
                        end else begin
                            div_r <= div_r - DIV_ONE;
                        end
                    end
                end
                ST_GAP: begin
                    if (stop) begin
                        state_r <= ST_IDLE;
                        sq_r    <= 1'b0;
                        busy_r  <= 1'b0;
                    end else if (slot_r == SLOT_ZERO) begin
                        state_r <= ST_TONE;
                        slot_r  <= SLOT_LAST;
                        div_r   <= HALF_A_LAST;
                    end else begin
                        slot_r <= slot_r - SLOT_ONE;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    sq_r    <= 1'b0;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = busy_r;
    assign done = done_r;

`ifdef ALARM_TONE_GEN_VOLUME_EN
    logic [2:0] pwm_cnt_r;
    logic       gate_r;

    // Free-running PWM counter and registered volume gate (volume is not latched).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_cnt_r <= 3'd0;
            gate_r    <= 1'b0;
        end else begin
            pwm_cnt_r <= pwm_cnt_r + 3'd1;
            // full scale must be ungated, which pwm < 7 alone would not give
            gate_r    <= (volume == 3'd7) || ((pwm_cnt_r + 3'd1) < volume);
        end
    end

    assign speaker = sq_r & gate_r;
`else
    logic unused_volume_s;
    assign unused_volume_s = ^volume;
    assign speaker = sq_r;
`endif

endmodule

// File: tb/tb_alarm_tone_gen.sv
// Self-checking bench for alarm_tone_gen (CLK_HZ=1000, HALF_A=5, HALF_B=2, SLOT=20).
// A table of directed scenarios plus randomized scenarios are compared cycle by
// cycle against a reference model computed from elapsed time since start.
module tb_alarm_tone_gen;

    localparam int HA  = 5;
    localparam int HB  = 2;
    localparam int SL  = 20;
    localparam int INF = 1_000_000;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] mode;
    logic [3:0] count;
    logic       start;
    logic       stop;
    logic [2:0] volume;
    logic       speaker;
    logic       busy;
    logic       done;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    alarm_tone_gen #(
        .CLK_HZ   (1000),
        .TONE_A_HZ(100),
        .TONE_B_HZ(250),
        .SLOT_MS  (20)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .mode   (mode),
        .count  (count),
        .start  (start),
        .stop   (stop),
        .volume (volume),
        .speaker(speaker),
        .busy   (busy),
        .done   (done)
    );

    typedef struct {
        logic [1:0] mode;
        logic [3:0] count;
        bit         stop_with_start;
        int         stop_at;     // stop applied so that busy lasts stop_at cycles; 0 = never
        bit         start_mid;   // extra start pulse while busy
        int         exp_busy;    // expected number of busy cycles
        int         exp_done;    // expected number of done pulses
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Natural playback length in cycles, from the mode/count rules.
    function automatic int nat_len(input int m, input int c);
        if (m == 0) return 0;
        if (m == 1 || c == 0) return INF;
        if (m == 2) return (2 * c - 1) * SL;
        return 2 * c * SL;
    endfunction

    // Expected square wave t cycles after the start was accepted.
    function automatic logic model_sq(input int m, input int t);
        int k, u, h;
        logic l;
        k = t / SL;
        u = t % SL;
        if (m == 1) return ((t / HA) % 2) == 1;
        if (m == 2) return (k % 2 == 0) && (((u / HA) % 2) == 1);
        l = 1'b0;
        for (int j = 0; j < k; j++) begin
            h = (j % 2 == 1) ? HB : HA;
            if (((SL - 1) / h) % 2 == 1) l = ~l;
        end
        h = (k % 2 == 1) ? HB : HA;
        return l ^ (((u / h) % 2) == 1);
    endfunction

    task automatic run(input int m, input int c, input bit sws, input int stop_at,
                       input bit mid, output int busy_cnt, output int done_cnt);
        int  len;
        bit  natural;
        logic exp_s;
        len = sws ? 0 : nat_len(m, c);
        natural = (len > 0);
        if (stop_at > 0 && stop_at <= len) begin
            len = stop_at;
            natural = 1'b0;
        end
        busy_cnt = 0;
        done_cnt = 0;
        mode  = 2'(m);
        count = 4'(c);
        start = 1'b1;
        stop  = sws;
        tick();
        start = 1'b0;
        stop  = 1'b0;
        mode  = 2'($urandom_range(0, 3));
        count = 4'($urandom_range(0, 15));
        for (int t = 0; t < len + 4; t++) begin
            exp_s = (t < len) ? model_sq(m, t) : 1'b0;
            check("busy", busy, (t < len) ? 1 : 0);
            check("speaker", speaker, exp_s);
            check("done", done, (natural && t == len) ? 1 : 0);
            busy_cnt += int'(busy);
            done_cnt += int'(done);
            stop  = (stop_at > 0 && t == stop_at - 1);
            start = mid && (t == 30) && (t < len);
            if (start) mode = 2'($urandom_range(1, 3));
            tick();
        end
        start = 1'b0;
        stop  = 1'b0;
    endtask

    vec_t tbl[12];
    int   bc, dc;

    initial begin
        int   m, c, nl, sa;
        bit   sws, mid;
        int   hi;

        tbl[0]  = '{2'd1, 4'd0, 1'b0, 100, 1'b0, 100, 0};
        tbl[1]  = '{2'd2, 4'd2, 1'b0, 0,   1'b0, 60,  1};
        tbl[2]  = '{2'd3, 4'd1, 1'b0, 0,   1'b0, 40,  1};
        tbl[3]  = '{2'd2, 4'd1, 1'b0, 0,   1'b0, 20,  1};
        tbl[4]  = '{2'd2, 4'd3, 1'b0, 0,   1'b0, 100, 1};
        tbl[5]  = '{2'd3, 4'd2, 1'b0, 0,   1'b0, 80,  1};
        tbl[6]  = '{2'd2, 4'd2, 1'b0, 0,   1'b1, 60,  1};
        tbl[7]  = '{2'd0, 4'd2, 1'b0, 0,   1'b0, 0,   0};
        tbl[8]  = '{2'd2, 4'd2, 1'b1, 0,   1'b0, 0,   0};
        tbl[9]  = '{2'd2, 4'd0, 1'b0, 90,  1'b0, 90,  0};
        tbl[10] = '{2'd3, 4'd0, 1'b0, 150, 1'b0, 150, 0};
        tbl[11] = '{2'd2, 4'd2, 1'b0, 60,  1'b0, 60,  0};

        rst_n  = 1'b0;
        mode   = 2'd0;
        count  = 4'd0;
        start  = 1'b0;
        stop   = 1'b0;
        volume = 3'd7;
        #20;
        rst_n = 1'b1;
        tick();

        // reset state and idle behaviour, including stop while idle
        for (int i = 0; i < 50; i++) begin
            check("idle_speaker", speaker, 0);
            check("idle_busy", busy, 0);
            check("idle_done", done, 0);
            stop = (i == 10);
            tick();
        end
        stop = 1'b0;

        // directed table
        for (int i = 0; i < 12; i++) begin
            run(tbl[i].mode, tbl[i].count, tbl[i].stop_with_start, tbl[i].stop_at,
                tbl[i].start_mid, bc, dc);
            check($sformatf("vec%0d_busy_len", i), bc, tbl[i].exp_busy);
            check($sformatf("vec%0d_done_cnt", i), dc, tbl[i].exp_done);
        end

        // asynchronous reset in the middle of a tone high phase
        mode  = 2'd1;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        check("pre_reset_speaker", speaker, 1);
        check("pre_reset_busy", busy, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_speaker", speaker, 0);
        check("async_busy", busy, 0);
        check("async_done", done, 0);
        #1;
        rst_n = 1'b1;
        tick();
        check("post_reset_busy", busy, 0);

        // randomized scenarios
        for (int r = 0; r < 25; r++) begin
            m   = $urandom_range(0, 3);
            c   = $urandom_range(0, 3);
            nl  = nat_len(m, c);
            sws = ($urandom_range(0, 7) == 0);
            mid = ($urandom_range(0, 1) == 1);
            if (nl >= INF) sa = $urandom_range(1, 130);
            else if (nl > 0 && $urandom_range(0, 1) == 1) sa = $urandom_range(1, nl);
            else sa = 0;
            run(m, c, sws, sa, mid, bc, dc);
        end

`ifdef ALARM_TONE_GEN_VOLUME_EN
        // PWM gating: volume=2 passes only part of the high phases, volume=0 is silent
        volume = 3'd2;
        mode   = 2'd1;
        start  = 1'b1;
        tick();
        start = 1'b0;
        hi = 0;
        for (int t = 0; t < 80; t++) begin
            check("vol2_gated", speaker & ~model_sq(1, t), 0);
            hi += int'(speaker);
            tick();
        end
        check("vol2_high_count_in_range", (hi >= 5 && hi <= 15) ? 1 : 0, 1);
        volume = 3'd0;
        tick();
        for (int t = 0; t < 40; t++) begin
            check("vol0_silent", speaker, 0);
            tick();
        end
        stop = 1'b1;
        tick();
        stop   = 1'b0;
        volume = 3'd7;
        tick();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    // Global time guard so the run always terminates.
    initial begin
        #2_000_000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/alarm_tone_gen.md
# alarm_tone_gen

Parametrised square-wave tone generator for the panel speaker/buzzer, the next generation of the fixed 440 Hz buzzer. It adds programmable tones, four playback modes (off, continuous, beep cadence, two-tone warble), a finite beep/warble count with a start/busy/done handshake, and optional PWM volume. It sits between the alarm/timer control logic and the speaker output pin.

## Interface
- CLK_HZ, 50_000_000, system clock frequency; must be a multiple of 1000
- TONE_A_HZ, 440, primary tone; HALF_A = CLK_HZ/(2*TONE_A_HZ) cycles
- TONE_B_HZ, 880, secondary (warble) tone; HALF_B = CLK_HZ/(2*TONE_B_HZ)
- SLOT_MS, 250, cadence slot length; SLOT = (CLK_HZ/1000)*SLOT_MS cycles
- clk  input  1  system clock, all logic on rising edge
- rst_n  input  1  asynchronous, active-low reset
- mode  input  2  0=OFF, 1=CONT, 2=BEEP, 3=WARBLE; sampled on accepted start
- count  input  4  beeps (BEEP) or A/B pairs (WARBLE); 0 = indefinite; sampled on accepted start
- start  input  1  single-cycle request to begin playback
- stop  input  1  abort playback
- volume  input  3  PWM level; used only with the volume macro
- speaker  output  1  square-wave drive to buzzer
- busy  output  1  high while playing
- done  output  1  one-cycle pulse on natural completion

## Operation
- States: IDLE, TONE, GAP. Speaker = 0 in IDLE and GAP.
- IDLE: start=1 with mode≠OFF → latch mode/count, load slot counter with SLOT-1, load divider with HALF_A-1, speaker=0, go to TONE. Start with mode=OFF is ignored.
- Divider: in TONE, decrements each cycle; at 0 toggles speaker and reloads the active HALF-1.
- CONT: stays in TONE until stop; slot counter is unused.
- BEEP: TONE for SLOT cycles, then GAP for SLOT cycles, repeat. After the count-th TONE slot, go to IDLE with no trailing gap. count=0 loops forever.
- WARBLE: no GAP. Slots alternate A, B, A, B… At each slot boundary the divider reloads with the new HALF-1 and speaker keeps its current level. Completes after count A/B pairs; count=0 loops forever.
- Remaining-count register decrements at the end of each TONE (BEEP) or B slot (WARBLE). On natural completion: done=1 for one cycle, busy=0 in the same cycle, speaker=0.
- stop in TONE/GAP → IDLE next edge, speaker=0, busy=0, no done pulse.
- stop and start in the same cycle: stop wins (start ignored). stop in IDLE: no effect.
- start while busy: ignored. mode/count changes while busy: ignored.
- Widths: divider $clog2(max(HALF_A,HALF_B)), slot counter $clog2(SLOT). No overflow is possible by construction.

## Timing
- Reset values: speaker=0, busy=0, done=0, state=IDLE, all counters 0.
- Start accepted at edge N → busy=1 and state TONE after edge N.
- First speaker rise occurs HALF_A cycles after entering TONE; the period is 2*HALF_A cycles.
- BEEP with count=n: busy high for (2n-1)*SLOT cycles; done coincides with the first IDLE cycle.
- WARBLE with count=n: busy high for 2n*SLOT cycles.
- Reset asserted mid-playback: all outputs return to reset values immediately (asynchronous).

## Configuration
- ALARM_TONE_GEN_VOLUME_EN defined: a free-running 3-bit PWM counter gates the output.
  - speaker = sq & (pwm_cnt < volume); volume=7 forces ungated output; volume=0 gives silence.
  - volume is sampled continuously, not latched.
- Not defined: volume is ignored and speaker = square wave directly.

## Test plan
Bench parameters: CLK_HZ=1000, TONE_A_HZ=100 (HALF_A=5), TONE_B_HZ=250 (HALF_B=2), SLOT_MS=20 (SLOT=20).
- Reset then idle 50 cycles → speaker=0, busy=0, done=0 throughout; async rst_n low mid-TONE → outputs 0 without a clock edge.
- mode=1, start pulse, stop after 100 cycles → speaker toggles every 5 cycles (first rise 5 cycles after busy), busy falls the cycle after stop, no done.
- mode=2, count=2 → pattern 20 tone / 20 silent / 20 tone; busy high 60 cycles; done one cycle as busy falls.
- mode=3, count=1 → 20 cycles at half-period 5, then 20 at half-period 2, no silent gap at the switch; busy 40 cycles; done pulse.
- start+stop same cycle in IDLE → no busy; start while busy in BEEP → ignored, total length unchanged; mode=0 start → ignored.
- With ALARM_TONE_GEN_VOLUME_EN: mode=1, volume=2 → speaker high only 2 of every 8 cycles inside square-wave high phases; volume=0 → speaker always 0.
